// File: rtl/meteor_draw.sv
// meteor_draw: per-frame erase/redraw of the meteor square over the shared
// pixel-write bus. The block latches position and enable on the frame strobe,
// erases the square currently on screen, then draws the square at the new
// position. Pixels outside 320x240 are skipped without waiting for a grant.
// All outputs except o_plot are registered copies of the decode of the next
// state, so they always match the state registers.
module meteor_draw #(
    parameter int         SIZE      = 8,
    parameter logic [2:0] COLOUR    = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       i_clk,
    input  logic       m_reset,
    input  logic       m_frame,
    input  logic       enable,
    input  logic [9:0] m_x,
    input  logic [8:0] m_y,
    input  logic       i_grant,
    output logic       o_req,
    output logic       o_plot,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic [2:0] o_colour,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overrun
);

    localparam int            CW   = $clog2(SIZE) + 32'sd1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 32'sd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    old_x_q, old_x_d, new_x_q, new_x_d;
    logic [8:0]    old_y_q, old_y_d, new_y_q, new_y_d;
    logic          old_valid_q, old_valid_d, new_en_q, new_en_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic          overrun_q, overrun_d;
    logic          req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;

    logic          step_s, last_s;
    logic [9:0]    base_x_s;
    logic [8:0]    base_y_s;
    logic [10:0]   sum_x_s;
    logic [9:0]    sum_y_s;
    logic          on_s;

    // Next-state logic: frame capture, row-major scan, square bookkeeping.
    always_comb begin
        state_d     = state_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        new_en_d    = new_en_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        // A skipped (off-screen) pixel advances without a grant.
        step_s      = ~req_q | i_grant;
        last_s      = (cx_q == LAST) && (cy_q == LAST);
        case (state_q)
            IDLE: begin
                if (m_frame) begin
                    new_x_d  = m_x;
                    new_y_d  = m_y;
                    new_en_d = enable;
                    cx_d     = {CW{1'b0}};
                    cy_d     = {CW{1'b0}};
                    if (old_valid_q) begin
                        state_d = ERASE;
                    end else if (enable) begin
                        state_d = DRAW;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ERASE, DRAW: begin
                if (step_s) begin
                    if (last_s) begin
                        cx_d = {CW{1'b0}};
                        cy_d = {CW{1'b0}};
                        if (state_q == ERASE && new_en_q) begin
                            state_d = DRAW;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (cx_q == LAST) begin
                        cx_d = {CW{1'b0}};
                        cy_d = cy_q + CW'(1'b1);
                    end else begin
                        cx_d = cx_q + CW'(1'b1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            FINISH: begin
                old_x_d     = new_x_q;
                old_y_d     = new_y_q;
                old_valid_d = new_en_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A strobe anywhere but IDLE (FINISH included) is dropped and latched.
        if (m_frame && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Output decode of the next state, registered below so outputs track state.
    always_comb begin
        base_x_s = (state_d == ERASE) ? old_x_d : new_x_d;
        base_y_s = (state_d == ERASE) ? old_y_d : new_y_d;
        sum_x_s  = {1'b0, base_x_s} + {{(11 - CW){1'b0}}, cx_d};
        sum_y_s  = {1'b0, base_y_s} + {{(10 - CW){1'b0}}, cy_d};
        on_s     = ((state_d == ERASE) || (state_d == DRAW)) &&
                   (sum_x_s <= 11'd319) && (sum_y_s <= 10'd239);
        req_d    = on_s;
        if (on_s) begin
            x_d      = sum_x_s[9:0];
            y_d      = sum_y_s[8:0];
            colour_d = (state_d == ERASE) ? BG_COLOUR : COLOUR;
        end else begin
            x_d      = 10'd0;
            y_d      = 9'd0;
            colour_d = 3'b000;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State, square bookkeeping and registered outputs; async active-high reset.
    always_ff @(posedge i_clk or posedge m_reset) begin
        if (m_reset) begin
            state_q     <= IDLE;
            old_x_q     <= 10'd0;
            old_y_q     <= 9'd0;
            old_valid_q <= 1'b0;
            new_x_q     <= 10'd0;
            new_y_q     <= 9'd0;
            new_en_q    <= 1'b0;
            cx_q        <= {CW{1'b0}};
            cy_q        <= {CW{1'b0}};
            overrun_q   <= 1'b0;
            req_q       <= 1'b0;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            colour_q    <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            new_en_q    <= new_en_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            overrun_q   <= overrun_d;
            req_q       <= req_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_req     = req_q;
    assign o_plot    = req_q & i_grant;
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_colour  = colour_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_overrun = overrun_q;

endmodule
